// File: rtl/f32_normalize_round.sv
// Post-add normalize and round stage producing a packed IEEE-754 single.
// Define F32_ROUND_NEAREST_EN for round-to-nearest-even; the default build truncates.
module f32_normalize_round #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [EW-1:0] in_exp,
  input  logic [MW+3:0] in_mant,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   r,
  output logic          overflow,
  output logic          underflow
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  // One spare exponent bit so exp+1 on a carry can reach the overflow range.
  localparam int XW = EW + 1;
  localparam logic [XW-1:0] EXP_ONE = {{(XW-1){1'b0}}, 1'b1};
  localparam logic [XW-1:0] EXP_MAX = {1'b0, {EW{1'b1}}};

  state_t        state_q, state_d;
  logic          sign_q, sign_d;
  logic [XW-1:0] exp_q, exp_d;
  logic [MW+3:0] mant_q, mant_d;
  logic          nz_q, nz_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   r_q, r_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          round_inc;
  logic [MW+1:0] rnd_sum;
  logic [XW-1:0] rnd_exp;
  logic [MW-1:0] rnd_frac;

  always_comb begin
`ifdef F32_ROUND_NEAREST_EN
    round_inc = mant_q[1] & (mant_q[0] | mant_q[2]);
`else
    round_inc = 1'b0;
`endif
    rnd_sum  = {1'b0, mant_q[MW+2:2]} + {{(MW+1){1'b0}}, round_inc};
    rnd_exp  = exp_q;
    rnd_frac = rnd_sum[MW-1:0];
    // A denormal that rounds up into the hidden bit becomes the smallest normal.
    if (rnd_sum[MW+1]) begin
      rnd_frac = rnd_sum[MW:1];
      rnd_exp  = exp_q + EXP_ONE;
    end else if (exp_q == '0 && rnd_sum[MW]) begin
      rnd_exp = EXP_ONE;
    end
  end

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mant_d      = mant_q;
    nz_d        = nz_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    r_d         = r_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sign_d     = in_sign;
          exp_d      = {1'b0, in_exp};
          mant_d     = in_mant;
          nz_d       = |in_mant;
          in_ready_d = 1'b0;
          state_d    = NORM;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      NORM: begin
        if (mant_q == '0) begin
          r_d         = {sign_q, {(EW+MW){1'b0}}};
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (mant_q[MW+3]) begin
          mant_d  = {1'b0, mant_q[MW+3:2], |mant_q[1:0]};
          exp_d   = exp_q + EXP_ONE;
          state_d = ROUND;
        end else if (mant_q[MW+2]) begin
          state_d = ROUND;
        end else if (exp_q <= EXP_ONE) begin
          exp_d   = '0;
          state_d = ROUND;
        end else begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - EXP_ONE;
        end
      end
      ROUND: begin
        out_valid_d = 1'b1;
        state_d     = DONE;
        if (rnd_exp >= EXP_MAX) begin
          r_d         = {sign_q, {EW{1'b1}}, {MW{1'b0}}};
          overflow_d  = 1'b1;
          underflow_d = 1'b0;
        end else begin
          r_d         = {sign_q, rnd_exp[EW-1:0], rnd_frac};
          overflow_d  = 1'b0;
          underflow_d = nz_q && (rnd_exp[EW-1:0] == '0);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      nz_q        <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      r_q         <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      nz_q        <= nz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      r_q         <= r_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign r         = r_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_f32_normalize_round.sv
// Directed-vector bench for f32_normalize_round with hand-computed expected results.
module tb_f32_normalize_round;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [26:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] r;
  logic        overflow;
  logic        underflow;

  int errors = 0;
  int checks = 0;

  f32_normalize_round dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Offers one operand and returns the handshake-to-out_valid latency in cycles.
  task automatic applyStimulus(input logic s, input logic [7:0] e, input logic [26:0] m, output int lat);
    int wait_cnt;
    wait_cnt = 0;
    @(negedge clk);
    while (!in_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    checkOutput("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic popResult();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic runVector(input string tag, input logic s, input logic [7:0] e, input logic [26:0] m,
                           input logic [31:0] exp_r, input logic exp_ovf, input logic exp_unf, input int exp_lat);
    int lat;
    applyStimulus(s, e, m, lat);
    checkOutput({tag, "_latency"}, lat, exp_lat);
    checkOutput({tag, "_r"}, r, exp_r);
    checkOutput({tag, "_overflow"}, {31'b0, overflow}, {31'b0, exp_ovf});
    checkOutput({tag, "_underflow"}, {31'b0, underflow}, {31'b0, exp_unf});
    popResult();
  endtask

  initial begin
    int lat;
    int ov_seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_r", r, 32'd0);
    checkOutput("rst_overflow", {31'b0, overflow}, 32'd0);
    checkOutput("rst_underflow", {31'b0, underflow}, 32'd0);

    // Release with in_valid high: no transfer may happen on the release edge.
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_exp   = 8'd127;
    in_mant  = 27'h2000000;
    #1 checkOutput("release_in_ready_low", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1 checkOutput("release_in_ready_high", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b0;
    checkOutput("release_no_output", {31'b0, out_valid}, 32'd0);

    runVector("one",       1'b0, 8'd127, 27'h2000000, 32'h3F800000, 1'b0, 1'b0, 3);
    runVector("carry",     1'b0, 8'd127, 27'h4000000, 32'h40000000, 1'b0, 1'b0, 3);
    runVector("ovf",       1'b0, 8'd254, 27'h4000000, 32'h7F800000, 1'b1, 1'b0, 3);
    runVector("lshift5",   1'b0, 8'd127, 27'h0100000, 32'h3D000000, 1'b0, 1'b0, 8);
`ifdef F32_ROUND_NEAREST_EN
    runVector("round",     1'b0, 8'd127, 27'h2000003, 32'h3F800001, 1'b0, 1'b0, 3);
    runVector("roundcarry",1'b0, 8'd127, 27'h3FFFFFE, 32'h40000000, 1'b0, 1'b0, 3);
`else
    runVector("round",     1'b0, 8'd127, 27'h2000003, 32'h3F800000, 1'b0, 1'b0, 3);
    runVector("roundcarry",1'b0, 8'd127, 27'h3FFFFFE, 32'h3FFFFFFF, 1'b0, 1'b0, 3);
`endif
    runVector("denorm",    1'b0, 8'd1,   27'h1000000, 32'h00400000, 1'b0, 1'b1, 3);
    runVector("negzero",   1'b1, 8'd1,   27'h0000000, 32'h80000000, 1'b0, 1'b0, 2);
    runVector("neg",       1'b1, 8'd128, 27'h3000000, 32'hC0400000, 1'b0, 1'b0, 3);

    // Backpressure: result held while out_ready stays low, new offers ignored.
    applyStimulus(1'b0, 8'd128, 27'h2000000, lat);
    checkOutput("stall_r0", r, 32'h40000000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_exp   = 8'd10;
      in_mant  = 27'h0000001;
      checkOutput("stall_r", r, 32'h40000000);
      checkOutput("stall_out_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("stall_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    popResult();
    #1 checkOutput("post_pop_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("post_pop_out_valid", {31'b0, out_valid}, 32'd0);

    // Reset pulsed while the operation is still shifting in NORM.
    @(negedge clk);
    in_sign  = 1'b0;
    in_exp   = 8'd127;
    in_mant  = 27'h0100000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midrst_r", r, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ov_seen = 0;
    @(posedge clk);
    #1 checkOutput("midrst_release_in_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 if (out_valid) ov_seen++;
    end
    checkOutput("midrst_no_result", ov_seen, 32'd0);

    runVector("after_rst", 1'b0, 8'd127, 27'h3000000, 32'h3FC00000, 1'b0, 1'b0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
